// File: rtl/radius_ctrl.sv
// Radius controller: plus/minus buttons with press, hold and auto-repeat
// stepping of a saturating radius, gated by the game mode flags.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   plus, minus        asynchronous button levels
//   gamemenu, gamerun,
//   gamepause          mode flags (MENU restores R_INIT, RUN steps)
//   r                  registered radius
//   at_min, at_max     r at a limit
//   changed            one-cycle pulse after r takes a new value
module radius_ctrl #(
    parameter int W          = 6,
    parameter int R_MIN      = 10,
    parameter int R_MAX      = 50,
    parameter int R_INIT     = 50,
    parameter int R_STEP     = 10,
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         plus,
    input  logic         minus,
    input  logic         gamemenu,
    input  logic         gamerun,
    input  logic         gamepause,
    output logic [W-1:0] r,
    output logic         at_min,
    output logic         at_max,
    output logic         changed
);

    localparam int CMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [W-1:0]  RMIN  = W'(R_MIN);
    localparam logic [W-1:0]  RMAX  = W'(R_MAX);
    localparam logic [W-1:0]  RINIT = W'(R_INIT);
    localparam logic [W:0]    STEPW = (W+1)'(R_STEP);
    localparam logic [W:0]    LOWB  = (W+1)'(R_MIN + R_STEP);
    localparam logic [CW-1:0] HLAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RLAST = CW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} st_t;

    logic          menu, run;
    logic [1:0]    s1, s2, prev;
    logic          v1, v2;
    st_t           st  [2];
    logic [CW-1:0] cnt [2];
    logic [1:0]    ev;
    logic [W:0]    up;
    logic [W-1:0]  r_nx;

    assign menu = gamemenu & ~gamerun & ~gamepause;
    assign run  = gamerun & ~gamemenu & ~gamepause;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    // Bit 0 is plus, bit 1 is minus. prev reads as "high" until the
    // synchroniser has produced a real sample, so a button held through
    // reset never looks like a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            prev <= 2'b11;
        end else begin
            s1   <= {minus, plus};
            s2   <= s1;
            v1   <= 1'b1;
            v2   <= v1;
            prev <= v2 ? s2 : 2'b11;
        end
    end

    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++) begin
            if (run && s2[i]) begin
                unique case (st[i])
                    IDLE:    ev[i] = ~prev[i];
                    WAIT:    ev[i] = (cnt[i] == HLAST);
                    REPEAT:  ev[i] = (cnt[i] == RLAST);
                    default: ev[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!run || !s2[i]) begin
                    st[i]  <= IDLE;
                    cnt[i] <= '0;
                end else begin
                    unique case (st[i])
                        IDLE: begin
                            if (ev[i]) begin
                                st[i]  <= WAIT;
                                cnt[i] <= '0;
                            end
                        end
                        WAIT: begin
                            if (ev[i]) begin
                                st[i]  <= REPEAT;
                                cnt[i] <= '0;
                            end else begin
                                cnt[i] <= inc(cnt[i]);
                            end
                        end
                        REPEAT: begin
                            if (ev[i]) cnt[i] <= '0;
                            else       cnt[i] <= inc(cnt[i]);
                        end
                        default: begin
                            st[i]  <= IDLE;
                            cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Simultaneous grow and shrink cancel out.
    always_comb begin
        up   = {1'b0, r} + STEPW;
        r_nx = r;
        if (menu) begin
            r_nx = RINIT;
        end else if (run && (ev[0] ^ ev[1])) begin
            if (ev[0])
                r_nx = (up > {1'b0, RMAX}) ? RMAX : up[W-1:0];
            else
                r_nx = ({1'b0, r} < LOWB) ? RMIN : r - STEPW[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r       <= RINIT;
            changed <= 1'b0;
        end else begin
            r       <= r_nx;
            changed <= (r_nx != r);
        end
    end

    assign at_min = (r == RMIN);
    assign at_max = (r == RMAX);

endmodule
